// File: rtl/bsg_link_pkg.sv
// Shared link constants: channel geometry, credit window and beat-to-byte-lane map.
// Lane numbers are byte offsets inside the 32-bit half currently being assembled.
package bsg_link_pkg;

  localparam int LINK_CH       = 2;
  localparam int LINK_CH_W     = 8;
  localparam int LINK_HALF_W   = LINK_CH * LINK_CH_W * 2;
  localparam int LINK_WORD_W   = 2 * LINK_HALF_W;
  localparam int TOKEN_HALVES  = 4;
  localparam int CREDIT_HALVES = 8;

  typedef enum logic {P = 1'b0, N = 1'b1} rx_phase_e;

  localparam int LANE_P_CH0 = 0;
  localparam int LANE_P_CH1 = 2;
  localparam int LANE_N_CH0 = 1;
  localparam int LANE_N_CH1 = 3;

  function automatic int lane_lsb(input logic half, input int lane);
    return (half ? LINK_HALF_W : 0) + LINK_CH_W * lane;
  endfunction

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// 1R1W synchronous FIFO with registered head; a write lands one cycle before it is visible.
// A push while full is accepted only if the same cycle pops; a pop while empty is ignored.
module bsg_link_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the slot being written.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_downstream_rx.sv
// Link receiver: reassembles four P/N beats into a 64-bit word, buffers it, returns credits.
// Word visible 1 cycle after its last beat; core pops via valid/ready; one token per TOKEN_WORDS pops.
module bsg_downstream_rx
  import bsg_link_pkg::*;
#(
  parameter int FIFO_WORDS  = CREDIT_HALVES / 2,
  parameter int TOKEN_WORDS = TOKEN_HALVES / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   io_valid_in,
  input  logic [LINK_CH_W-1:0]   io_data_in_ch0,
  input  logic [LINK_CH_W-1:0]   io_data_in_ch1,
  output logic                   io_token_out,
  output logic [LINK_WORD_W-1:0] core_data_out,
  output logic                   core_valid_out,
  input  logic                   core_ready_in,
  output logic                   overflow_err
);

  localparam int TCW = $clog2(TOKEN_WORDS) + 1;

  rx_phase_e              state_r, state_n;
  logic                   half_r;
  logic [LINK_WORD_W-1:0] asm_r, asm_n;
  logic                   cap_p, cap_n, push, pop;
  logic                   fifo_full, fifo_empty;
  logic [TCW-1:0]         tok_cnt_r, tok_cnt_inc;

  always_comb begin
    state_n = state_r;
    cap_p   = 1'b0;
    cap_n   = 1'b0;
    case (state_r)
      P: if (io_valid_in) begin
        cap_p   = 1'b1;
        state_n = N;
      end
      N: begin
        cap_n   = 1'b1;
        state_n = P;
      end
      default: state_n = P;
    endcase
  end

  // The N beat of half 1 pushes the word including the bytes arriving this cycle.
  always_comb begin
    asm_n = asm_r;
    if (cap_p) begin
      asm_n[lane_lsb(half_r, LANE_P_CH0) +: LINK_CH_W] = io_data_in_ch0;
      asm_n[lane_lsb(half_r, LANE_P_CH1) +: LINK_CH_W] = io_data_in_ch1;
    end
    if (cap_n) begin
      asm_n[lane_lsb(half_r, LANE_N_CH0) +: LINK_CH_W] = io_data_in_ch0;
      asm_n[lane_lsb(half_r, LANE_N_CH1) +: LINK_CH_W] = io_data_in_ch1;
    end
  end

  assign push           = cap_n & half_r;
  assign core_valid_out = ~fifo_empty;
  assign pop            = core_valid_out & core_ready_in;
  assign tok_cnt_inc    = tok_cnt_r + 1'b1;

  bsg_link_rx_fifo #(
    .WIDTH(LINK_WORD_W),
    .DEPTH(FIFO_WORDS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(asm_n),
    .pop      (pop),
    .head     (core_data_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= P;
      half_r       <= 1'b0;
      asm_r        <= '0;
      tok_cnt_r    <= '0;
      io_token_out <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_r      <= state_n;
      asm_r        <= asm_n;
      io_token_out <= 1'b0;
      if (cap_n) half_r <= ~half_r;
      if (pop) begin
        if (tok_cnt_inc == TCW'(TOKEN_WORDS)) begin
          tok_cnt_r    <= '0;
          io_token_out <= 1'b1;
        end else begin
          tok_cnt_r <= tok_cnt_inc;
        end
      end
      if (push && fifo_full && !pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_downstream_rx.sv
// Directed bench for bsg_downstream_rx: word reassembly, tokens, overflow, full+pop, reset, gaps.
// A negedge monitor scores every pop against the expected-word queue and every token cycle.
module tb_bsg_downstream_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_valid_in = 1'b0;
  logic [7:0]  io_data_in_ch0 = 8'h00;
  logic [7:0]  io_data_in_ch1 = 8'h00;
  logic        io_token_out;
  logic [63:0] core_data_out;
  logic        core_valid_out;
  logic        core_ready_in = 1'b0;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;
  int tokens = 0;
  int mpops  = 0;
  logic tok_exp = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] wv [5] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978,
                          64'h1357_9BDF_2468_ACE0};

  always #5 clk = ~clk;

  bsg_downstream_rx dut (
    .clk           (clk),
    .rst           (rst),
    .io_valid_in   (io_valid_in),
    .io_data_in_ch0(io_data_in_ch0),
    .io_data_in_ch1(io_data_in_ch1),
    .io_token_out  (io_token_out),
    .core_data_out (core_data_out),
    .core_valid_out(core_valid_out),
    .core_ready_in (core_ready_in),
    .overflow_err  (overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // A pop on posedge k must give io_token_out high in the following cycle when it is the 2nd, 4th ... pop.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      mpops   = 0;
      tok_exp = 1'b0;
      tokens  = 0;
    end else begin
      chk("token_pulse", {63'd0, io_token_out}, {63'd0, tok_exp});
      tok_exp = 1'b0;
      if (io_token_out) tokens++;
      if (core_valid_out && core_ready_in) begin
        if (exp_q.size() == 0) chk("pop_unexpected", {63'd0, core_valid_out}, 64'd0);
        else chk("pop_data", core_data_out, exp_q.pop_front());
        mpops++;
        if (mpops % 2 == 0) tok_exp = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    io_valid_in   = 1'b0;
    core_ready_in = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    chk("rst_valid", {63'd0, core_valid_out}, 64'd0);
    chk("rst_data", core_data_out, 64'd0);
    chk("rst_token", {63'd0, io_token_out}, 64'd0);
    chk("rst_ovf", {63'd0, overflow_err}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int g0, input int g1,
                           input logic vn, input logic pop_last);
    for (int h = 0; h < 2; h++) begin
      repeat (h == 0 ? g0 : g1) begin
        io_valid_in    = 1'b0;
        io_data_in_ch0 = 8'hEE;
        io_data_in_ch1 = 8'hEE;
        cyc();
      end
      io_valid_in    = 1'b1;
      io_data_in_ch0 = w[32*h +: 8];
      io_data_in_ch1 = w[32*h+16 +: 8];
      cyc();
      io_valid_in    = vn;
      io_data_in_ch0 = w[32*h+8 +: 8];
      io_data_in_ch1 = w[32*h+24 +: 8];
      if (h == 1 && pop_last) core_ready_in = 1'b1;
      cyc();
      if (h == 1 && pop_last) core_ready_in = 1'b0;
    end
    io_valid_in = 1'b0;
  endtask

  task automatic pop_one();
    core_ready_in = 1'b1;
    cyc();
    core_ready_in = 1'b0;
  endtask

  initial begin
    // 1: single word, byte-lane mapping and 1-cycle latency
    do_reset();
    exp_q.push_back(64'h8877_6655_4433_2211);
    send_word(64'h8877_6655_4433_2211, 0, 0, 1'b0, 1'b0);
    chk("t1_valid", {63'd0, core_valid_out}, 64'd1);
    chk("t1_data", core_data_out, 64'h8877_6655_4433_2211);
    pop_one();
    chk("t1_empty", {63'd0, core_valid_out}, 64'd0);

    // 2: ready high, four back-to-back words, two tokens
    do_reset();
    core_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(wv[i]);
    for (int i = 0; i < 4; i++) send_word(wv[i], 0, 0, 1'b0, 1'b0);
    repeat (3) cyc();
    core_ready_in = 1'b0;
    chk("t2_tokens", 64'(tokens), 64'd2);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: ready low, five words, fifth dropped
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(wv[i]);
    for (int i = 0; i < 4; i++) send_word(wv[i], 0, 0, 1'b0, 1'b0);
    chk("t3_ovf_before", {63'd0, overflow_err}, 64'd0);
    send_word(wv[4], 0, 0, 1'b0, 1'b0);
    chk("t3_ovf", {63'd0, overflow_err}, 64'd1);
    chk("t3_head", core_data_out, wv[0]);
    repeat (4) pop_one();
    chk("t3_empty", {63'd0, core_valid_out}, 64'd0);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    cyc();
    cyc();
    chk("t3_tokens", 64'(tokens), 64'd2);
    chk("t3_ovf_sticky", {63'd0, overflow_err}, 64'd1);

    // 4: full FIFO, fifth word's last beat coincides with a pop
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(wv[i]);
    for (int i = 0; i < 4; i++) send_word(wv[i], 0, 0, 1'b0, 1'b0);
    send_word(wv[4], 0, 0, 1'b0, 1'b1);
    chk("t4_ovf", {63'd0, overflow_err}, 64'd0);
    chk("t4_head", core_data_out, wv[1]);
    for (int i = 0; i < 4; i++) begin
      chk("t4_occ", {63'd0, core_valid_out}, 64'd1);
      pop_one();
    end
    chk("t4_empty", {63'd0, core_valid_out}, 64'd0);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    cyc();
    cyc();
    chk("t4_tokens", 64'(tokens), 64'd2);

    // 5: reset after the first half of a word discards it
    do_reset();
    io_valid_in = 1'b1; io_data_in_ch0 = 8'h11; io_data_in_ch1 = 8'h33;
    cyc();
    io_valid_in = 1'b0; io_data_in_ch0 = 8'h22; io_data_in_ch1 = 8'h44;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_no_partial", {63'd0, core_valid_out}, 64'd0);
    exp_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 1'b0, 1'b0);
    chk("t5_valid", {63'd0, core_valid_out}, 64'd1);
    chk("t5_data", core_data_out, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t5_tokens", 64'(tokens), 64'd0);
    pop_one();
    chk("t5_empty", {63'd0, core_valid_out}, 64'd0);

    // 6: valid asserted on every N beat, idle gaps of 0-3 cycles between halves
    do_reset();
    exp_q.push_back(wv[0]);
    exp_q.push_back(wv[1]);
    exp_q.push_back(wv[2]);
    send_word(wv[0], 1, 3, 1'b1, 1'b0);
    send_word(wv[1], 2, 0, 1'b1, 1'b0);
    send_word(wv[2], 0, 2, 1'b1, 1'b0);
    chk("t6_head", core_data_out, wv[0]);
    chk("t6_ovf", {63'd0, overflow_err}, 64'd0);
    repeat (3) pop_one();
    chk("t6_empty", {63'd0, core_valid_out}, 64'd0);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
